// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg
//   Shared types for the instruction-memory loader of the 4-bit CPU.
//   - instruction_t  : one instruction word (opcode + operand nibble)
//   - loader_state_t : loader FSM states
//   - LOADER_ADDR_WIDTH / LOADER_INSTR_WIDTH : default loader geometry
package prog_loader_pkg;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] operand;
  } instruction_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    HOLD,
    RUN,
    ERROR
  } loader_state_t;

  localparam int LOADER_ADDR_WIDTH  = 4;
  localparam int LOADER_INSTR_WIDTH = $bits(instruction_t);

endpackage

// File: rtl/prog_loader.sv
// prog_loader
//   Loads a stream of instruction words into the CPU instruction memory.
//   A load command (load_start with load_base/load_count) is followed by a
//   valid/ready word stream. Each accepted word is written straight into
//   memory. The CPU is held in reset for the whole load and for RESET_HOLD
//   cycles afterwards, then released (RUN). A new load may start from IDLE,
//   RUN or ERROR.
//
//   Optional build macro: PROG_LOADER_CHECKSUM_EN
//     When defined, a running XOR of the written words is kept and one extra
//     word, the checksum, is expected after the data. A bad checksum parks
//     the FSM in ERROR with load_error set.
//
//   Ports
//     clk, reset      : clock, synchronous active-high reset
//     load_start      : one-cycle load request (with load_base, load_count)
//     in_valid/in_data/in_ready : instruction word stream
//     mem_we/mem_addr/mem_wdata : instruction memory write port
//     prog_enable     : address-mux select, 1 = loader owns memory address
//     cpu_reset       : CPU reset, active-high
//     load_done       : one-cycle pulse on entry to RUN
//     load_error      : high while in ERROR
//     words_loaded    : words written in the current or last load
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_WIDTH  = LOADER_ADDR_WIDTH,
  parameter int INSTR_WIDTH = LOADER_INSTR_WIDTH,
  parameter int RESET_HOLD  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_start,
  input  logic [ADDR_WIDTH-1:0]  load_base,
  input  logic [ADDR_WIDTH:0]    load_count,
  input  logic                   in_valid,
  input  logic [INSTR_WIDTH-1:0] in_data,
  output logic                   in_ready,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [INSTR_WIDTH-1:0] mem_wdata,
  output logic                   prog_enable,
  output logic                   cpu_reset,
  output logic                   load_done,
  output logic                   load_error,
  output logic [ADDR_WIDTH:0]    words_loaded
);

  localparam int HOLD_WIDTH = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(RESET_HOLD - 1);

  loader_state_t         state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [HOLD_WIDTH-1:0] hold_cnt;
  logic                  start_ok;
  logic                  handshake;
  logic                  last_word;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [INSTR_WIDTH-1:0] checksum;
  logic                   error_flag;
  assign load_error = error_flag;
`else
  assign load_error = 1'b0;
`endif

  assign start_ok  = load_start && (state == IDLE || state == RUN || state == ERROR);
  assign handshake = in_valid && in_ready;

  // Writes happen on the handshake edge itself; CHECK also raises in_ready
  // but must never write, hence the explicit LOAD qualifier.
  assign mem_we    = (state == LOAD) && handshake;
  assign mem_addr  = addr;
  assign mem_wdata = in_data;

  // LOAD ends either on the handshake that consumes the final word, or after
  // its single cycle when the load was for zero words.
  assign last_word = (state == LOAD) &&
                     ((remaining == '0) ||
                      (handshake && remaining == (ADDR_WIDTH + 1)'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cpu_reset    <= 1'b1;
      prog_enable  <= 1'b0;
      in_ready     <= 1'b0;
      load_done    <= 1'b0;
      words_loaded <= '0;
      addr         <= '0;
      remaining    <= '0;
      hold_cnt     <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      checksum     <= '0;
      error_flag   <= 1'b0;
`endif
    end else begin
      load_done <= 1'b0;
      if (start_ok) begin
        state        <= LOAD;
        addr         <= load_base;
        remaining    <= load_count;
        words_loaded <= '0;
        cpu_reset    <= 1'b1;
        prog_enable  <= 1'b1;
        in_ready     <= (load_count != '0);
`ifdef PROG_LOADER_CHECKSUM_EN
        checksum     <= '0;
        error_flag   <= 1'b0;
`endif
      end else begin
        case (state)
          LOAD: begin
            if (handshake) begin
              addr         <= addr + 1'b1;
              remaining    <= remaining - 1'b1;
              words_loaded <= words_loaded + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
              checksum     <= checksum ^ in_data;
`endif
            end
            if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state       <= CHECK;
              in_ready    <= 1'b1;
`else
              state       <= HOLD;
              in_ready    <= 1'b0;
              prog_enable <= 1'b0;
              hold_cnt    <= '0;
`endif
            end
          end
`ifdef PROG_LOADER_CHECKSUM_EN
          CHECK: begin
            if (handshake) begin
              in_ready    <= 1'b0;
              prog_enable <= 1'b0;
              if (in_data == checksum) begin
                state    <= HOLD;
                hold_cnt <= '0;
              end else begin
                state      <= ERROR;
                error_flag <= 1'b1;
              end
            end
          end
`endif
          HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
              state     <= RUN;
              cpu_reset <= 1'b0;
              load_done <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
//   Self-checking bench for prog_loader (default build, checksum disabled).
//   A table of load commands is applied with random data and gap patterns;
//   a reference memory image computed from (base + k) mod depth is compared
//   with the image rebuilt from the observed write port.
module tb_prog_loader;

  localparam int AW    = 4;
  localparam int IW    = 8;
  localparam int RH    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_start = 1'b0;
  logic [AW-1:0] load_base = '0;
  logic [AW:0]   load_count = '0;
  logic          in_valid = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_wdata;
  logic          prog_enable;
  logic          cpu_reset;
  logic          load_done;
  logic          load_error;
  logic [AW:0]   words_loaded;

  prog_loader #(
    .ADDR_WIDTH (AW),
    .INSTR_WIDTH(IW),
    .RESET_HOLD (RH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_start  (load_start),
    .load_base   (load_base),
    .load_count  (load_count),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .prog_enable (prog_enable),
    .cpu_reset   (cpu_reset),
    .load_done   (load_done),
    .load_error  (load_error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   count;
    int            mode;
    bit            poke;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] last_addr;
  } load_vec_t;

  int            n_cmp = 0;
  int            n_fail = 0;
  logic [IW-1:0] ref_mem [DEPTH];
  logic [IW-1:0] dut_mem [DEPTH];
  logic [AW-1:0] wr_addr_q [$];
  logic [IW-1:0] wr_data_q [$];
  load_vec_t     vecs [8];

  // Write-port monitor, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit pick_valid(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic drain_writes();
    for (int k = 0; k < wr_addr_q.size(); k++) dut_mem[wr_addr_q[k]] = wr_data_q[k];
  endtask

  task automatic check_output();
    for (int k = 0; k < DEPTH; k++) check($sformatf("mem[%0d]", k), dut_mem[k], ref_mem[k]);
  endtask

  task automatic apply_stimulus(input load_vec_t v);
    logic [IW-1:0] data [DEPTH];
    int  i, cyc, hold_n;
    bit  ready_bad, poked, acc, first;
    logic pe_first;
    for (int k = 0; k < DEPTH; k++) data[k] = IW'($urandom);
    wr_addr_q.delete();
    wr_data_q.delete();

    @(posedge clk); #1;
    load_start = 1'b1;
    load_base  = v.base;
    load_count = v.count;
    @(posedge clk); #1;
    load_start = 1'b0;
    load_base  = AW'($urandom);
    load_count = (AW + 1)'($urandom);
    check("enter_cpu_reset", cpu_reset, 1);
    check("enter_prog_enable", prog_enable, 1);
    check("enter_in_ready", in_ready, (v.count != 0));

    i = 0; cyc = 0; poked = 0; ready_bad = 0;
    while (i < int'(v.count) && cyc < 400) begin
      if (v.poke && i == 1 && !poked) begin
        load_start = 1'b1;
        load_base  = ~v.base;
        load_count = 1;
        in_valid   = 1'b0;
        poked      = 1;
      end else begin
        load_start = 1'b0;
        in_valid   = pick_valid(v.mode, cyc);
      end
      in_data = data[i];
      @(negedge clk);
      if (in_ready !== 1'b1) ready_bad = 1;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    load_start = 1'b0;
    in_valid   = 1'b0;
    check("words_accepted", i, v.count);
    check("ready_held", ready_bad, 0);

    hold_n = 0; first = 1; pe_first = 1'bx;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (first) begin
        pe_first = prog_enable;
        first = 0;
      end
      if (cpu_reset !== 1'b1) break;
      hold_n++;
    end
    check("hold_cycles", hold_n, RH + ((v.count == 0) ? 1 : 0));
    check("prog_enable_after_last", pe_first, (v.count == 0));
    check("load_done_pulse", load_done, 1);
    check("words_loaded", words_loaded, v.count);
    @(negedge clk);
    check("load_done_clear", load_done, 0);
    check("run_cpu_reset", cpu_reset, 0);
    check("run_prog_enable", prog_enable, 0);

    for (int k = 0; k < int'(v.count); k++) ref_mem[(int'(v.base) + k) % DEPTH] = data[k];
    check("write_count", wr_addr_q.size(), v.count);
    if (v.count != 0 && wr_addr_q.size() > 0) begin
      check("first_addr", wr_addr_q[0], v.first_addr);
      check("last_addr", wr_addr_q[wr_addr_q.size() - 1], v.last_addr);
    end
    for (int k = 0; k < wr_addr_q.size() && k < int'(v.count); k++) begin
      check("write_addr", wr_addr_q[k], (int'(v.base) + k) % DEPTH);
      check("write_data", wr_data_q[k], data[k]);
    end
    drain_writes();
    check_output();
  endtask

  initial begin
    load_vec_t tail;
    logic [IW-1:0] part [5];
    for (int k = 0; k < DEPTH; k++) begin
      ref_mem[k] = '0;
      dut_mem[k] = '0;
    end

    //          base   count  mode poke first  last
    vecs[0] = '{4'd0,  5'd12, 0,   1'b0, 4'd0,  4'd11};
    vecs[1] = '{4'd3,  5'd4,  1,   1'b0, 4'd3,  4'd6};
    vecs[2] = '{4'd14, 5'd4,  0,   1'b0, 4'd14, 4'd1};
    vecs[3] = '{4'd0,  5'd16, 2,   1'b0, 4'd0,  4'd15};
    vecs[4] = '{4'd5,  5'd0,  0,   1'b0, 4'd0,  4'd0};
    vecs[5] = '{4'd2,  5'd3,  0,   1'b1, 4'd2,  4'd4};
    vecs[6] = '{4'd9,  5'd7,  2,   1'b0, 4'd9,  4'd15};
    vecs[7] = '{4'd12, 5'd10, 2,   1'b0, 4'd12, 4'd5};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_prog_enable", prog_enable, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_load_done", load_done, 0);
    check("rst_load_error", load_error, 0);
    check("rst_words_loaded", words_loaded, 0);
    check("rst_mem_we", mem_we, 0);

    foreach (vecs[n]) apply_stimulus(vecs[n]);

    // Reset after 5 of 10 words: already-written words must stay in memory.
    wr_addr_q.delete();
    wr_data_q.delete();
    @(posedge clk); #1;
    load_start = 1'b1;
    load_base  = 0;
    load_count = 10;
    @(posedge clk); #1;
    load_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      part[k]  = IW'($urandom);
      in_valid = 1'b1;
      in_data  = part[k];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_cpu_reset", cpu_reset, 1);
    check("midrst_prog_enable", prog_enable, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_words_loaded", words_loaded, 0);
    @(negedge clk);
    check("midrst_write_count", wr_addr_q.size(), 5);
    for (int k = 0; k < 5; k++) ref_mem[k] = part[k];
    drain_writes();
    check_output();

    tail = '{4'd7, 5'd3, 0, 1'b0, 4'd7, 4'd9};
    apply_stimulus(tail);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
